// File: rtl/fa_fault_tester_if.sv
// ============================================================================
//  Module      : fa_fault_tester_if
//  Description : Bundle of handshake, stimulus/response and result signals
//                between a full-adder fault tester and its environment.
//                master : environment side (drives start and adder responses)
//                slave  : tester side (drives stimulus, status and results)
//  Signals     : start, dut_sum, dut_carry, test_a/b/cin, busy, done,
//                fault_detected, fault_code[2:0], mismatch_count[3:0],
//                first_fail_vec[2:0], response_log[15:0]
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fa_fault_tester_if;
    logic        start;
    logic        dut_sum;
    logic        dut_carry;
    logic        test_a;
    logic        test_b;
    logic        test_cin;
    logic        busy;
    logic        done;
    logic        fault_detected;
    logic [2:0]  fault_code;
    logic [3:0]  mismatch_count;
    logic [2:0]  first_fail_vec;
    logic [15:0] response_log;

    modport master (
        output start, dut_sum, dut_carry,
        input  test_a, test_b, test_cin, busy, done, fault_detected,
               fault_code, mismatch_count, first_fail_vec, response_log
    );

    modport slave (
        input  start, dut_sum, dut_carry,
        output test_a, test_b, test_cin, busy, done, fault_detected,
               fault_code, mismatch_count, first_fail_vec, response_log
    );
endinterface

`default_nettype wire

// File: rtl/fa_fault_tester.sv
// ============================================================================
//  Module      : fa_fault_tester
//  Description : Sweeps all eight {a,b,cin} vectors through a full adder,
//                compares its sum/carry against a golden model and classifies
//                the fault (0 none, 1 sum s-a-0, 2 sum s-a-1, 3 carry s-a-0,
//                4 carry s-a-1, 5 other/multiple).
//  Ports       : clk, rst (sync, active-high), bus (fa_fault_tester_if.slave)
//  Parameters  : SETTLE_CYCLES (1..15) cycles each vector is held before
//                sampling.
//  Macro       : FA_TESTER_SIGNATURE_EN - when defined, capture the raw
//                {carry,sum} response of each vector into response_log;
//                otherwise response_log is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_fault_tester #(
    parameter int SETTLE_CYCLES = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fa_fault_tester_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] C_CODE_NONE   = 3'd0;
    localparam logic [2:0] C_CODE_SUM0   = 3'd1;
    localparam logic [2:0] C_CODE_SUM1   = 3'd2;
    localparam logic [2:0] C_CODE_CARRY0 = 3'd3;
    localparam logic [2:0] C_CODE_CARRY1 = 3'd4;
    localparam logic [2:0] C_CODE_OTHER  = 3'd5;

    state_t      r_state, w_state_next;
    logic        w_busy, w_done, w_accept;

    logic [2:0]  r_v;
    logic [3:0]  r_cnt;
    logic [3:0]  r_mis;
    logic [2:0]  r_first;
    logic        r_sum_err, r_carry_err;
    logic        r_sum_all0, r_sum_all1, r_carry_all0, r_carry_all1;
    logic [2:0]  r_code;
    logic        r_fault;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_APPLY;
                end
            end
            S_APPLY: begin
                w_busy = 1'b1;
                if (r_cnt == C_SETTLE_LAST) w_state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                w_busy       = 1'b1;
                w_state_next = (r_v == 3'd7) ? S_DONE : S_APPLY;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- golden model and comparison ----------------
    logic w_exp_sum, w_exp_carry, w_sum_bad, w_carry_bad;
    logic w_sum_err_n, w_carry_err_n;
    logic w_sum_all0_n, w_sum_all1_n, w_carry_all0_n, w_carry_all1_n;
    logic [3:0] w_mis_n;
    logic [2:0] w_code_n;

    assign w_exp_sum   = ^r_v;
    assign w_exp_carry = (r_v[2] & r_v[1]) | (r_v[2] & r_v[0]) | (r_v[1] & r_v[0]);
    assign w_sum_bad   = (bus.dut_sum   != w_exp_sum);
    assign w_carry_bad = (bus.dut_carry != w_exp_carry);

    // Accumulator values including the vector being sampled now, so the
    // classification can be registered on the same edge that enters DONE.
    assign w_sum_err_n    = r_sum_err   | w_sum_bad;
    assign w_carry_err_n  = r_carry_err | w_carry_bad;
    assign w_sum_all0_n   = r_sum_all0   & ~bus.dut_sum;
    assign w_sum_all1_n   = r_sum_all1   &  bus.dut_sum;
    assign w_carry_all0_n = r_carry_all0 & ~bus.dut_carry;
    assign w_carry_all1_n = r_carry_all1 &  bus.dut_carry;
    assign w_mis_n        = r_mis + {3'b000, (w_sum_bad | w_carry_bad)};

    always_comb begin
        w_code_n = C_CODE_OTHER;
        if (w_mis_n == 4'd0)
            w_code_n = C_CODE_NONE;
        else if (w_sum_err_n && !w_carry_err_n && w_sum_all0_n)
            w_code_n = C_CODE_SUM0;
        else if (w_sum_err_n && !w_carry_err_n && w_sum_all1_n)
            w_code_n = C_CODE_SUM1;
        else if (w_carry_err_n && !w_sum_err_n && w_carry_all0_n)
            w_code_n = C_CODE_CARRY0;
        else if (w_carry_err_n && !w_sum_err_n && w_carry_all1_n)
            w_code_n = C_CODE_CARRY1;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v          <= 3'd0;
            r_cnt        <= 4'd0;
            r_mis        <= 4'd0;
            r_first      <= 3'd0;
            r_sum_err    <= 1'b0;
            r_carry_err  <= 1'b0;
            r_sum_all0   <= 1'b0;
            r_sum_all1   <= 1'b0;
            r_carry_all0 <= 1'b0;
            r_carry_all1 <= 1'b0;
            r_code       <= 3'd0;
            r_fault      <= 1'b0;
        end else if (w_accept) begin
            r_v          <= 3'd0;
            r_cnt        <= 4'd0;
            r_mis        <= 4'd0;
            r_first      <= 3'd0;
            r_sum_err    <= 1'b0;
            r_carry_err  <= 1'b0;
            // "constant over all samples" flags start true and get knocked down
            r_sum_all0   <= 1'b1;
            r_sum_all1   <= 1'b1;
            r_carry_all0 <= 1'b1;
            r_carry_all1 <= 1'b1;
            r_code       <= 3'd0;
            r_fault      <= 1'b0;
        end else if (r_state == S_APPLY) begin
            r_cnt <= (r_cnt == C_SETTLE_LAST) ? 4'd0 : r_cnt + 4'd1;
        end else if (r_state == S_SAMPLE) begin
            r_mis        <= w_mis_n;
            // r_mis still zero means no earlier mismatch in this run
            if ((w_sum_bad || w_carry_bad) && r_mis == 4'd0)
                r_first <= r_v;
            r_sum_err    <= w_sum_err_n;
            r_carry_err  <= w_carry_err_n;
            r_sum_all0   <= w_sum_all0_n;
            r_sum_all1   <= w_sum_all1_n;
            r_carry_all0 <= w_carry_all0_n;
            r_carry_all1 <= w_carry_all1_n;
            if (r_v != 3'd7) begin
                r_v <= r_v + 3'd1;
            end else begin
                r_code  <= w_code_n;
                r_fault <= (w_mis_n != 4'd0);
            end
        end
    end

`ifdef FA_TESTER_SIGNATURE_EN
    logic [15:0] r_log;
    always_ff @(posedge clk) begin
        if (rst)
            r_log <= 16'h0000;
        else if (w_accept)
            r_log <= 16'h0000;
        else if (r_state == S_SAMPLE)
            r_log[{r_v, 1'b0} +: 2] <= {bus.dut_carry, bus.dut_sum};
    end
    assign bus.response_log = r_log;
`else
    assign bus.response_log = 16'h0000;
`endif

    assign bus.test_a         = r_v[2];
    assign bus.test_b         = r_v[1];
    assign bus.test_cin       = r_v[0];
    assign bus.busy           = w_busy;
    assign bus.done           = w_done;
    assign bus.fault_detected = r_fault;
    assign bus.fault_code     = r_code;
    assign bus.mismatch_count = r_mis;
    assign bus.first_fail_vec = r_first;

endmodule

`default_nettype wire

// File: tb/tb_fa_fault_tester.sv
// ============================================================================
//  Module      : tb_fa_fault_tester
//  Description : Self-checking bench for fa_fault_tester. Contains a
//                behavioural fault-injectable full adder (selector 0..4 plus
//                a sum-invert mode) and directed scenarios with hand-computed
//                expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fa_fault_tester;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    int   cyc;
    int   fsel;
    logic inv_sum;

    fa_fault_tester_if bus ();

    fa_fault_tester #(.SETTLE_CYCLES(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Fault-injectable adder model
    logic w_gs, w_gc;
    assign w_gs = bus.test_a ^ bus.test_b ^ bus.test_cin;
    assign w_gc = (bus.test_a & bus.test_b) | (bus.test_a & bus.test_cin) |
                  (bus.test_b & bus.test_cin);
    assign bus.dut_sum   = inv_sum ? ~w_gs :
                           (fsel == 1) ? 1'b0 : (fsel == 2) ? 1'b1 : w_gs;
    assign bus.dut_carry = (fsel == 3) ? 1'b0 : (fsel == 4) ? 1'b1 : w_gc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Pulse start so it is sampled at "edge 0"; on return we are in cycle 1.
    task automatic launch();
        tick();
        bus.start = 1'b1;
        cyc = 0;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        while (bus.done !== 1'b1 && cyc < 60) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
        n_total++; if ({bus.test_a, bus.test_b, bus.test_cin} !== 3'b000)
            $display("FAIL reset_stim got %b want 000", {bus.test_a, bus.test_b, bus.test_cin}); else n_pass++;
        n_total++; if (bus.fault_code !== 3'd0) $display("FAIL reset_code got %0d want 0", bus.fault_code); else n_pass++;
        n_total++; if (bus.mismatch_count !== 4'd0) $display("FAIL reset_mis got %0d want 0", bus.mismatch_count); else n_pass++;
        n_total++; if (bus.fault_detected !== 1'b0) $display("FAIL reset_det got %b want 0", bus.fault_detected); else n_pass++;
        n_total++; if (bus.response_log !== 16'h0) $display("FAIL reset_log got %h want 0000", bus.response_log); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_no_fault();
        fsel = 0; inv_sum = 1'b0;
        launch();
        n_total++; if (bus.busy !== 1'b1) $display("FAIL nf_busy_c1 got %b want 1", bus.busy); else n_pass++;
        wait_done();
        n_total++; if (cyc !== 17) $display("FAIL nf_done_cycle got %0d want 17", cyc); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL nf_busy_at_done got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.fault_code !== 3'd0) $display("FAIL nf_code got %0d want 0", bus.fault_code); else n_pass++;
        n_total++; if (bus.mismatch_count !== 4'd0) $display("FAIL nf_mis got %0d want 0", bus.mismatch_count); else n_pass++;
        n_total++; if (bus.fault_detected !== 1'b0) $display("FAIL nf_det got %b want 0", bus.fault_detected); else n_pass++;
`ifdef FA_TESTER_SIGNATURE_EN
        n_total++; if (bus.response_log !== 16'hE994) $display("FAIL nf_log got %h want e994", bus.response_log); else n_pass++;
`else
        n_total++; if (bus.response_log !== 16'h0000) $display("FAIL nf_log got %h want 0000", bus.response_log); else n_pass++;
`endif
        tick();
        n_total++; if (bus.done !== 1'b0) $display("FAIL nf_done_pulse got %b want 0", bus.done); else n_pass++;
    endtask

    task automatic test_sum_stuck0();
        fsel = 1; inv_sum = 1'b0;
        launch();
        wait_done();
        n_total++; if (bus.fault_code !== 3'd1) $display("FAIL s0_code got %0d want 1", bus.fault_code); else n_pass++;
        n_total++; if (bus.mismatch_count !== 4'd4) $display("FAIL s0_mis got %0d want 4", bus.mismatch_count); else n_pass++;
        n_total++; if (bus.first_fail_vec !== 3'd1) $display("FAIL s0_first got %0d want 1", bus.first_fail_vec); else n_pass++;
        n_total++; if (bus.fault_detected !== 1'b1) $display("FAIL s0_det got %b want 1", bus.fault_detected); else n_pass++;
        tick();
        n_total++; if (bus.fault_code !== 3'd1) $display("FAIL s0_hold got %0d want 1", bus.fault_code); else n_pass++;
    endtask

    task automatic test_sum_stuck1();
        fsel = 2; inv_sum = 1'b0;
        launch();
        wait_done();
        n_total++; if (bus.fault_code !== 3'd2) $display("FAIL s1_code got %0d want 2", bus.fault_code); else n_pass++;
        n_total++; if (bus.mismatch_count !== 4'd4) $display("FAIL s1_mis got %0d want 4", bus.mismatch_count); else n_pass++;
        n_total++; if (bus.first_fail_vec !== 3'd0) $display("FAIL s1_first got %0d want 0", bus.first_fail_vec); else n_pass++;
    endtask

    task automatic test_carry_stuck1();
        fsel = 4; inv_sum = 1'b0;
        launch();
        wait_done();
        n_total++; if (bus.fault_code !== 3'd4) $display("FAIL c1_code got %0d want 4", bus.fault_code); else n_pass++;
        n_total++; if (bus.mismatch_count !== 4'd4) $display("FAIL c1_mis got %0d want 4", bus.mismatch_count); else n_pass++;
        n_total++; if (bus.first_fail_vec !== 3'd0) $display("FAIL c1_first got %0d want 0", bus.first_fail_vec); else n_pass++;
    endtask

    task automatic test_restart_ignored();
        fsel = 0; inv_sum = 1'b1;
        launch();
        while (cyc < 5) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done();
        n_total++; if (cyc !== 17) $display("FAIL rs_done_cycle got %0d want 17", cyc); else n_pass++;
        n_total++; if (bus.fault_code !== 3'd5) $display("FAIL rs_code got %0d want 5", bus.fault_code); else n_pass++;
        n_total++; if (bus.mismatch_count !== 4'd8) $display("FAIL rs_mis got %0d want 8", bus.mismatch_count); else n_pass++;
        n_total++; if (bus.first_fail_vec !== 3'd0) $display("FAIL rs_first got %0d want 0", bus.first_fail_vec); else n_pass++;
    endtask

    task automatic test_mid_run_reset();
        fsel = 0; inv_sum = 1'b1;
        launch();
        while (cyc < 6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL mr_busy got %b want 0", bus.busy); else n_pass++;
        n_total++; if ({bus.test_a, bus.test_b, bus.test_cin} !== 3'b000)
            $display("FAIL mr_stim got %b want 000", {bus.test_a, bus.test_b, bus.test_cin}); else n_pass++;
        n_total++; if (bus.mismatch_count !== 4'd0) $display("FAIL mr_mis got %0d want 0", bus.mismatch_count); else n_pass++;
        n_total++; if (bus.fault_code !== 3'd0) $display("FAIL mr_code got %0d want 0", bus.fault_code); else n_pass++;
        n_total++; if (bus.response_log !== 16'h0) $display("FAIL mr_log got %h want 0000", bus.response_log); else n_pass++;
        fsel = 3; inv_sum = 1'b0;
        launch();
        wait_done();
        n_total++; if (cyc !== 17) $display("FAIL mr_done_cycle got %0d want 17", cyc); else n_pass++;
        n_total++; if (bus.fault_code !== 3'd3) $display("FAIL mr_c0_code got %0d want 3", bus.fault_code); else n_pass++;
        n_total++; if (bus.mismatch_count !== 4'd4) $display("FAIL mr_c0_mis got %0d want 4", bus.mismatch_count); else n_pass++;
        n_total++; if (bus.first_fail_vec !== 3'd3) $display("FAIL mr_c0_first got %0d want 3", bus.first_fail_vec); else n_pass++;
        n_total++; if (bus.fault_detected !== 1'b1) $display("FAIL mr_c0_det got %b want 1", bus.fault_detected); else n_pass++;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        cyc       = 0;
        fsel      = 0;
        inv_sum   = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        test_reset();
        test_no_fault();
        test_sum_stuck0();
        test_sum_stuck1();
        test_carry_stuck1();
        test_restart_ignored();
        test_mid_run_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
